// File: rtl/perip_arbiter_if.sv
// perip_arbiter_if: request/grant/ack bundle of both masters plus the peripheral data port
// slave  : arbiter view (takes requests and perip_rdata, drives gnt/ack/rdata, port and busy)
// master : requester/environment view, directions mirrored
interface perip_arbiter_if;
  logic        m0_req, m1_req;
  logic        m0_wen, m1_wen;
  logic [31:0] m0_addr, m1_addr;
  logic [1:0]  m0_mask, m1_mask;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] perip_addr;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [31:0] perip_wdata;
  logic [31:0] perip_rdata;
  logic        busy;
  modport slave (
    input  m0_req, m1_req, m0_wen, m1_wen, m0_addr, m1_addr, m0_mask, m1_mask,
           m0_wdata, m1_wdata, perip_rdata,
    output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
           perip_addr, perip_wen, perip_mask, perip_wdata, busy
  );
  modport master (
    output m0_req, m1_req, m0_wen, m1_wen, m0_addr, m1_addr, m0_mask, m1_mask,
           m0_wdata, m1_wdata, perip_rdata,
    input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
           perip_addr, perip_wen, perip_mask, perip_wdata, busy
  );
endinterface

// File: rtl/perip_arbiter.sv
// perip_arbiter: two-master fixed-priority arbiter with a starvation bound for the peripheral data port
// cpu_clk : rising-edge clock
// cpu_rst : asynchronous active-low reset
// bus     : perip_arbiter_if.slave (master requests, gnt/ack/rdata, peripheral port, busy)
module perip_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  perip_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t      state;
  logic        own;
  logic [3:0]  wait_cnt;
  logic        any_req;
  logic        win;
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    win     = bus.m1_req & (~bus.m0_req | (wait_cnt == LIM));
  end
  // read data arrives during RESP, so it is steered combinationally by the registered ack
  assign bus.m0_rdata = bus.m0_ack ? bus.perip_rdata : '0;
  assign bus.m1_rdata = bus.m1_ack ? bus.perip_rdata : '0;
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state           <= IDLE;
      own             <= 1'b0;
      wait_cnt        <= '0;
      bus.perip_addr  <= '0;
      bus.perip_wen   <= 1'b0;
      bus.perip_mask  <= '0;
      bus.perip_wdata <= '0;
      bus.m0_gnt      <= 1'b0;
      bus.m1_gnt      <= 1'b0;
      bus.m0_ack      <= 1'b0;
      bus.m1_ack      <= 1'b0;
      bus.busy        <= 1'b0;
    end else if (state == ACCESS) begin
      state         <= RESP;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.perip_wen <= 1'b0;
      bus.m0_ack    <= ~own;
      bus.m1_ack    <= own;
      bus.busy      <= 1'b1;
    end else begin
      state         <= any_req ? ACCESS : IDLE;
      bus.m0_ack    <= 1'b0;
      bus.m1_ack    <= 1'b0;
      bus.busy      <= any_req;
      bus.m0_gnt    <= any_req & ~win;
      bus.m1_gnt    <= any_req & win;
      bus.perip_wen <= any_req & (win ? bus.m1_wen : bus.m0_wen);
      if (any_req) begin
        own             <= win;
        bus.perip_addr  <= win ? bus.m1_addr  : bus.m0_addr;
        bus.perip_mask  <= win ? bus.m1_mask  : bus.m0_mask;
        bus.perip_wdata <= win ? bus.m1_wdata : bus.m0_wdata;
        wait_cnt        <= win ? 4'd0 : (bus.m1_req && wait_cnt < LIM) ? wait_cnt + 4'd1 : wait_cnt;
      end
    end
  end
endmodule
